riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
- Parametrised load/store unit for the next-generation multi-cycle RISC-V core; replaces the single-cycle CPU's direct combinational data-memory path.
- Accepts one load/store request at a time from the core.
- Drives a valid/ready memory bus that may insert wait states, with byte strobes and lane shifting on stores and lane extraction plus sign/zero extension on loads.
- Reports misaligned, illegal-size and bus-timeout faults; supports XLEN 32 or 64.

Parameters:
- XLEN, 32: data width, 32 or 64; STRB = XLEN/8 (derived).
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: maximum wait cycles in ACCESS before an access fault; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the LOAD/STORE instruction
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load result; 0 for stores and on error
- rsp_err  out  2  00 ok, 01 misaligned, 10 access fault (timeout), 11 illegal size
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  req_addr with the low log2(STRB) bits cleared
- mem_wstrb  out  STRB  byte enables; all 0 for loads
- mem_wdata  out  XLEN  store data shifted to the addressed lane
- mem_rdata  in  XLEN  read data, sampled when mem_valid && mem_ready
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE, mem_valid 0, rsp_valid 0, rsp_err 00, rsp_rdata 0, mem_we 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, timeout counter 0.
- Reset mid-ACCESS aborts the transaction immediately. mem_valid drops without a handshake and no response is issued.
- FSM states are IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. A request is accepted on req_valid.
  - Size is funct3[1:0]: byte, half, word, double.
  - Illegal size: doubleword or funct3 110 when XLEN = 32; funct3 111 in any configuration; store funct3[2] = 1. Illegal size goes to RESP with err 11.
  - Misaligned: the address is not a multiple of the size. Misaligned goes to RESP with err 01.
  - Neither error path touches the bus. Illegal size takes priority over misaligned.
  - Otherwise the unit registers the bus outputs and goes to ACCESS.
- ACCESS: mem_valid = 1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until the cycle where mem_ready = 1.
  - In that cycle the unit captures the load lane and goes to RESP with err 00.
  - The counter increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT (TIMEOUT > 0), mem_valid deasserts the next cycle and the unit goes to RESP with err 10.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion.
  - mem_ready outside ACCESS is ignored.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. The counter clears.
  - rsp_rdata and rsp_err hold their values until the next RESP.
  - There is no back-to-back accept in RESP (req_ready = 0).
- Latency: a request accepted at edge N gives mem_valid high from cycle N+1. With mem_ready at cycle M, rsp_valid is high in cycle M+1. Error path: rsp_valid in cycle N+1. Zero-wait memory gives a 2-cycle round trip.
- Strobes: byte = 1 << off; half = 3 << off; word = 0xF << off; double = all ones. off = addr mod STRB.
- mem_wdata = req_wdata << (8*off).
- Load extraction: lane = mem_rdata >> (8*off), truncated to the access size.
  - funct3[2] = 0 sign-extends to XLEN.
  - funct3[2] = 1 zero-extends (lbu/lhu/lwu).
- Stores return rsp_rdata = 0.

Test Plan:
- XLEN = 32, zero-wait. lb from 0x1003, mem_rdata = 0x80_00_00_00 -> mem_addr 0x1000, wstrb 0000, rsp_rdata 0xFFFF_FF80, err 00, rsp_valid exactly 2 cycles after accept.
- sh 0x0000_ABCD to 0x2002, mem_ready after 3 wait cycles -> mem_wstrb 1100, mem_wdata 0xABCD_0000, outputs stable through the waits, rsp_rdata 0, err 00.
- lw from 0x2001 -> no mem_valid, rsp_valid next cycle, err 01. ld (funct3 011) with XLEN = 32 at 0x2000 -> err 11.
- TIMEOUT = 4, mem_ready held 0 -> mem_valid for exactly 4 cycles, then rsp err 10, rsp_rdata 0, unit back in IDLE and req_ready = 1.
- XLEN = 64. lwu at 0x4004, mem_rdata = 0x8765_4321_0000_0000 -> rsp_rdata 0x0000_0000_8765_4321. sd -> wstrb 0xFF.
- reset asserted in ACCESS -> mem_valid 0 with no clock edge, no rsp_valid. After release, a new lbu completes normally.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// Bundled core-request, response and memory-bus signals of the load/store unit.
// The master modport is the LSU itself; the slave modport is the core plus the memory.
interface riscv_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int STRB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_err;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [STRB-1:0]   mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              busy;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr,
               mem_wstrb, mem_wdata, busy
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr,
               mem_wstrb, mem_wdata, busy
    );
endinterface

// File: rtl/riscv_lsu.sv
// Multi-cycle RISC-V load/store unit: one request at a time over a valid/ready bus,
// with lane steering, load extension and misaligned/illegal/timeout fault reporting.
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    riscv_lsu_if.master bus
);
    localparam int STRB  = XLEN / 8;
    localparam int OFF_W = $clog2(STRB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              mem_valid_r, mem_valid_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [STRB-1:0]   mem_wstrb_r, mem_wstrb_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [XLEN-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic [1:0]        rsp_err_r, rsp_err_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [2:0]        funct3_r, funct3_s;
    logic [OFF_W-1:0]  off_r, off_s;
    logic              req_ready_r, busy_r;
    logic              illegal_s, misaligned_s;
    logic [OFF_W-1:0]  req_off_s;

    function automatic logic [STRB-1:0] lane_strobe(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [STRB-1:0] base;
        case (size)
            2'b00:   base = STRB'(1'b1);
            2'b01:   base = STRB'(2'b11);
            2'b10:   base = STRB'(4'hF);
            default: base = {STRB{1'b1}};
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return low[0];
            2'b10:   return |low[1:0];
            default: return |low;
        endcase
    endfunction

    // lane is already shifted down to bit 0; funct3[2] selects zero extension
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3, input logic [XLEN-1:0] lane);
        case (funct3)
            3'b000:  return XLEN'($signed(lane[7:0]));
            3'b001:  return XLEN'($signed(lane[15:0]));
            3'b010:  return XLEN'($signed(lane[31:0]));
            3'b100:  return XLEN'(lane[7:0]);
            3'b101:  return XLEN'(lane[15:0]);
            3'b110:  return XLEN'(lane[31:0]);
            default: return lane;
        endcase
    endfunction

    // Request decode: illegal sizes and misalignment, illegal wins
    always_comb begin
        req_off_s    = bus.req_addr[OFF_W-1:0];
        illegal_s    = (bus.req_funct3 == 3'b111) ||
                       (bus.req_we && bus.req_funct3[2]) ||
                       ((XLEN == 32) && (bus.req_funct3[1:0] == 2'b11)) ||
                       ((XLEN == 32) && (bus.req_funct3 == 3'b110));
        misaligned_s = is_misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);
    end

    // Next-state and next-output logic of the IDLE/ACCESS/RESP machine
    always_comb begin
        state_s     = state_r;
        mem_valid_s = mem_valid_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wstrb_s = mem_wstrb_r;
        mem_wdata_s = mem_wdata_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        cnt_s       = cnt_r;
        funct3_s    = funct3_r;
        off_s       = off_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    funct3_s = bus.req_funct3;
                    off_s    = req_off_s;
                    if (illegal_s) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 2'b11;
                        rsp_rdata_s = {XLEN{1'b0}};
                    end else if (misaligned_s) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 2'b01;
                        rsp_rdata_s = {XLEN{1'b0}};
                    end else begin
                        state_s     = ST_ACCESS;
                        mem_valid_s = 1'b1;
                        mem_we_s    = bus.req_we;
                        mem_addr_s  = bus.req_addr & ~(ADDR_W'(STRB - 1));
                        mem_wstrb_s = bus.req_we ? lane_strobe(bus.req_funct3[1:0], req_off_s)
                                                 : {STRB{1'b0}};
                        mem_wdata_s = bus.req_we ? (bus.req_wdata << {req_off_s, 3'b000})
                                                 : {XLEN{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ready) begin
                    state_s     = ST_RESP;
                    mem_valid_s = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 2'b00;
                    rsp_rdata_s = mem_we_r ? {XLEN{1'b0}}
                                           : load_extend(funct3_r, bus.mem_rdata >> {off_r, 3'b000});
                end else if ((TIMEOUT > 0) && (cnt_r == CNT_W'(TIMEOUT - 1))) begin
                    // this is the TIMEOUT-th wait cycle, so the bus sees exactly TIMEOUT valid cycles
                    state_s     = ST_RESP;
                    mem_valid_s = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 2'b10;
                    rsp_rdata_s = {XLEN{1'b0}};
                    cnt_s       = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s     = ST_IDLE;
                mem_valid_s = 1'b0;
                cnt_s       = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any bus transaction at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wstrb_r <= {STRB{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 2'b00;
            cnt_r       <= {CNT_W{1'b0}};
            funct3_r    <= 3'b000;
            off_r       <= {OFF_W{1'b0}};
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_valid_r <= mem_valid_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wstrb_r <= mem_wstrb_s;
            mem_wdata_r <= mem_wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            cnt_r       <= cnt_s;
            funct3_r    <= funct3_s;
            off_r       <= off_s;
            req_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.busy      = busy_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wstrb = mem_wstrb_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule
